// File: rtl/pdm_pkg.sv
// Shared types and default parameters for the PDM microphone capture block.
package pdm_pkg;

    localparam int unsigned DEF_CLK_DIV    = 50;
    localparam int unsigned DEF_DECIM      = 64;
    localparam int unsigned DEF_WARMUP_WIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } pdm_state_e;

endpackage

// File: rtl/pdm_capture_if.sv
// PCM sample handshake between the capture block (master) and its sink (slave).
interface pdm_capture_if #(
    parameter int unsigned DECIM = 64
);
    localparam int unsigned PCM_W = $clog2(DECIM + 1);

    logic [PCM_W-1:0] pcm_data;
    logic             pcm_valid;
    logic             pcm_ready;

    modport master (output pcm_data, output pcm_valid, input pcm_ready);
    modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_clkgen.sv
// Microphone clock divider; rise_o pulses in the first clk cycle mic_clk_o is high.
import pdm_pkg::*;

module pdm_clkgen #(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic mic_clk_o,
    output logic rise_o
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             mic_clk_q, mic_clk_d;
    logic             rise_q, rise_d;

    always_comb begin
        div_d     = div_q;
        mic_clk_d = mic_clk_q;
        rise_d    = 1'b0;
        if (!run_i) begin
            div_d     = '0;
            mic_clk_d = 1'b0;
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d     = '0;
            mic_clk_d = !mic_clk_q;
            rise_d    = !mic_clk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            mic_clk_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            mic_clk_q <= mic_clk_d;
            rise_q    <= rise_d;
        end
    end

    assign mic_clk_o = mic_clk_q;
    assign rise_o    = rise_q;
endmodule

// File: rtl/pdm_capture.sv
// PDM microphone capture: popcount decimation into PCM samples with valid/ready output.
// Optional lost-sample counter on ovf_count when PDM_CAPTURE_OVF_CNT_EN is defined.
import pdm_pkg::*;

module pdm_capture #(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned DECIM      = DEF_DECIM,
    parameter int unsigned WARMUP_WIN = DEF_WARMUP_WIN
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          mic_data,
    output logic          mic_clk,
    output logic          mic_lrsel,
    pdm_capture_if.master pcm,
    output logic          overflow,
    output logic [15:0]   ovf_count
);
    localparam int unsigned PCM_W = $clog2(DECIM + 1);
    localparam int unsigned CNT_W = $clog2(DECIM);
    localparam int unsigned WIN_W = 8;

    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    logic [1:0]       sync_q;
    logic             rise_c;
    logic             lost_c;

    pdm_state_e       state_q, state_d;
    logic [PCM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [PCM_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    // Assert asynchronously, release two edges after reset deasserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) sync_q <= 2'b00;
        else            sync_q <= {sync_q[0], mic_data};
    end

    // Driven from next state so the mic clock stops on the same edge that enters IDLE.
    pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n_int),
        .run_i     (state_d != ST_IDLE),
        .mic_clk_o (mic_clk),
        .rise_o    (rise_c)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        data_d  = data_q;
        valid_d = valid_q;
        lost_c  = 1'b0;
        if (valid_q && pcm.pcm_ready) valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                win_d = '0;
                if (enable) state_d = (WARMUP_WIN == 0) ? ST_RUN : ST_WARMUP;
            end
            ST_WARMUP, ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    win_d   = '0;
                end else if (rise_c) begin
                    if (cnt_q == CNT_W'(DECIM - 1)) begin
                        acc_d = '0;
                        cnt_d = '0;
                        if (state_q == ST_WARMUP) begin
                            if (win_q == WIN_W'(WARMUP_WIN - 1)) begin
                                state_d = ST_RUN;
                                win_d   = '0;
                            end else begin
                                win_d = win_q + WIN_W'(1);
                            end
                        end else if (!valid_q || pcm.pcm_ready) begin
                            data_d  = acc_q + PCM_W'(sync_q[1]);
                            valid_d = 1'b1;
                        end else begin
                            lost_c = 1'b1;
                        end
                    end else begin
                        acc_d = acc_q + PCM_W'(sync_q[1]);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overflow_d = enable & (overflow_q | lost_c);
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            win_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PDM_CAPTURE_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Saturating count of dropped samples; only reset clears it.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int)                          ovf_cnt_q <= 16'h0000;
        else if (lost_c && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 16'h0000;
`endif

    assign mic_lrsel     = 1'b0;
    assign overflow      = overflow_q;
    assign pcm.pcm_data  = data_q;
    assign pcm.pcm_valid = valid_q;
endmodule

// File: tb/tb_pdm_capture.sv
// Directed/random bench for pdm_capture with a window-sum reference model.
`timescale 1ns/1ps
import pdm_pkg::*;

module tb_pdm_capture;
    localparam int unsigned DECIM = 64;
    localparam int unsigned WARM  = 2;
`ifdef PDM_CAPTURE_OVF_CNT_EN
    localparam int unsigned EXP_OVF = 1;
`else
    localparam int unsigned EXP_OVF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, mic_data;
    logic        mic_clk, mic_lrsel, overflow;
    logic [15:0] ovf_count;

    pdm_capture_if #(.DECIM(DECIM)) pcm_if ();

    pdm_capture #(.CLK_DIV(50), .DECIM(DECIM), .WARMUP_WIN(WARM)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mic_data  (mic_data),
        .mic_clk   (mic_clk),
        .mic_lrsel (mic_lrsel),
        .pcm       (pcm_if),
        .overflow  (overflow),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int mode     = 0;  // 0: all ones, 1: alternating, 2: random
    int exp_q[$];
    int m_bits, m_sum, m_win;

    // Data changes on mic_clk falls so every rise sees a settled bit.
    always @(negedge mic_clk) begin
        case (mode)
            0:       mic_data = 1'b1;
            1:       mic_data = ~mic_data;
            default: mic_data = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference: sum every DECIM bits seen at mic_clk rises; drop the first WARM windows.
    always @(posedge mic_clk or negedge enable or negedge reset) begin
        if (!enable || !reset) begin
            m_bits = 0; m_sum = 0; m_win = 0;
        end else begin
            m_sum += int'(mic_data);
            m_bits++;
            if (m_bits == DECIM) begin
                if (m_win >= WARM) exp_q.push_back(m_sum);
                else               m_win++;
                m_bits = 0; m_sum = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pcm_if.pcm_valid === 1'b1) break;
        end
    endtask

    task automatic pop_exp(output int v);
        if (exp_q.size() == 0) v = -1;
        else                   v = exp_q.pop_front();
    endtask

    // Wait until the model records a completed window; returns 1 on time-out.
    task automatic wait_push(input int budget, input logic [31:0] hold, output bit tmo, output bit stable);
        int c = 0;
        stable = 1'b1;
        while (exp_q.size() == 0 && c < budget) begin
            @(negedge clk);
            c++;
            if (pcm_if.pcm_data !== hold[6:0]) stable = 1'b0;
        end
        tmo = (exp_q.size() == 0);
    endtask

    initial begin
        int  cyc, ev, a_val;
        bit  tmo, stable;

        reset = 1'b0; enable = 1'b0; mic_data = 1'b1; pcm_if.pcm_ready = 1'b1;
        #1;
        chk("rst_mic_clk",   32'(mic_clk), 0);
        chk("rst_lrsel",     32'(mic_lrsel), 0);
        chk("rst_valid",     32'(pcm_if.pcm_valid), 0);
        chk("rst_data",      32'(pcm_if.pcm_data), 0);
        chk("rst_overflow",  32'(overflow), 0);
        chk("rst_ovf_count", 32'(ovf_count), 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_mic_clk", 32'(mic_clk), 0);

        // Constant ones: first RUN sample after two warm-up windows.
        enable = 1'b1;
        wait_valid(21000, cyc);
        chk("first_valid_seen", 32'(pcm_if.pcm_valid), 1);
        chk("first_valid_lat_ok", 32'(cyc >= 19100 && cyc <= 19300), 1);
        chk("ones_data0", 32'(pcm_if.pcm_data), 64);
        pop_exp(ev);
        chk("ones_model0", 32'(pcm_if.pcm_data), 32'(ev));
        @(negedge clk);
        chk("valid_drop_after_hs", 32'(pcm_if.pcm_valid), 0);
        wait_valid(7000, cyc);
        chk("ones_data1", 32'(pcm_if.pcm_data), 64);
        pop_exp(ev);

        // Alternating bits.
        mode = 1;
        @(negedge clk);
        wait_valid(7000, cyc);
        chk("alt_valid", 32'(pcm_if.pcm_valid), 1);
        chk("alt_data", 32'(pcm_if.pcm_data), 32);
        pop_exp(ev);
        chk("alt_model", 32'(pcm_if.pcm_data), 32'(ev));

        // Ready pulsed on the cycle of the next completion.
        mode = 2;
        @(negedge clk);
        pcm_if.pcm_ready = 1'b0;
        wait_valid(7000, cyc);
        pop_exp(ev);
        a_val = int'(pcm_if.pcm_data);
        chk("rnd_a_model", 32'(a_val), 32'(ev));
        wait_push(7000, 32'(a_val), tmo, stable);
        chk("push_b_timeout", 32'(tmo), 0);
        chk("hold_a_stable", 32'(stable), 1);
        pcm_if.pcm_ready = 1'b1;
        @(negedge clk);
        pcm_if.pcm_ready = 1'b0;
        pop_exp(ev);
        chk("coinc_valid", 32'(pcm_if.pcm_valid), 1);
        chk("coinc_new_data", 32'(pcm_if.pcm_data), 32'(ev));
        chk("coinc_no_ovf", 32'(overflow), 0);

        // Held sample meets another completion: drop the new one.
        a_val = int'(pcm_if.pcm_data);
        wait_push(7000, 32'(a_val), tmo, stable);
        chk("push_c_timeout", 32'(tmo), 0);
        repeat (2) @(negedge clk);
        pop_exp(ev);
        chk("ovf_hold_stable", 32'(stable), 1);
        chk("ovf_keep_data", 32'(pcm_if.pcm_data), 32'(a_val));
        chk("ovf_valid", 32'(pcm_if.pcm_valid), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(ovf_count), EXP_OVF);

        // Consume, then drop enable mid-window.
        pcm_if.pcm_ready = 1'b1;
        @(negedge clk);
        chk("consume_valid", 32'(pcm_if.pcm_valid), 0);
        repeat (3200) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_mic_clk", 32'(mic_clk), 0);
        chk("dis_state_idle", 32'(dut.state_q === ST_IDLE), 1);
        chk("dis_ovf_clear", 32'(overflow), 0);
        repeat (200) @(negedge clk);
        chk("dis_no_valid", 32'(pcm_if.pcm_valid), 0);
        chk("dis_mic_clk_idle", 32'(mic_clk), 0);

        // Re-enable: warm-up repeats; leave the sample pending for the reset check.
        pcm_if.pcm_ready = 1'b0;
        enable = 1'b1;
        wait_valid(21000, cyc);
        chk("reen_valid_seen", 32'(pcm_if.pcm_valid), 1);
        chk("reen_lat_ok", 32'(cyc >= 19100 && cyc <= 19300), 1);
        pop_exp(ev);
        chk("reen_model", 32'(pcm_if.pcm_data), 32'(ev));

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(pcm_if.pcm_valid), 0);
        chk("arst_data", 32'(pcm_if.pcm_data), 0);
        chk("arst_mic_clk", 32'(mic_clk), 0);
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_ovf_count", 32'(ovf_count), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pdm_capture.md
PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, giving system-clock cycles per mic_clk half-period (2 MHz from 200 MHz).
REQ-002 SHALL have parameter DECIM, default 64, giving PDM bits accumulated per PCM sample (range 2..255).
REQ-003 SHALL have parameter WARMUP_WIN, default 2, giving decimation windows discarded after enable.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: level; high runs capture, low returns to IDLE.
REQ-007 SHALL have port mic_data, input, 1 bit: asynchronous PDM data from the microphone.
REQ-008 SHALL have port mic_clk, output, 1 bit: clock driven to the microphone.
REQ-009 SHALL have port mic_lrsel, output, 1 bit: channel select, constant 0.
REQ-010 SHALL have port pcm_data, output, PCM_W = clog2(DECIM+1) bits: count of ones in the window.
REQ-011 SHALL have port pcm_valid, output, 1 bit: pcm_data holds an unconsumed sample.
REQ-012 SHALL have port pcm_ready, input, 1 bit: sink accepts the sample when pcm_valid and pcm_ready are both high.
REQ-013 SHALL have port overflow, output, 1 bit: sticky; set when a sample is lost, cleared by reset or when enable goes low.
REQ-014 SHALL have port ovf_count, output, 16 bits: number of lost samples (see Configuration).

Function
REQ-015 SHALL run a divider counter 0..CLK_DIV-1 that toggles mic_clk at terminal count, only in WARMUP and RUN; in IDLE, mic_clk = 0 and the counter = 0.
REQ-016 SHALL pass mic_data through a 2-flop synchronizer.
REQ-017 SHALL sample the synchronized bit in the clk cycle in which mic_clk toggles 0 to 1 (the rise event).
REQ-018 SHALL add each sampled bit into an accumulator and count bits; at the DECIM-th bit the window completes and the accumulator and bit count clear in the same cycle.
REQ-019 SHALL provide states IDLE, WARMUP and RUN.
REQ-020 SHALL transition IDLE->WARMUP when enable=1.
REQ-021 SHALL transition WARMUP->RUN after WARMUP_WIN completed windows; windows completed in WARMUP are discarded.
REQ-022 SHALL return any state to IDLE when enable=0, discarding the partial window; the output register keeps a pending sample until it is accepted.
REQ-023 SHALL, on each window completion in RUN, load pcm_data and assert pcm_valid on the next cycle (latency 1 clk after the rise event of the DECIM-th bit).
REQ-024 SHALL hold pcm_data stable while pcm_valid=1 and pcm_ready=0.
REQ-025 SHALL drop pcm_valid the cycle after the handshake unless a new sample loads in that same cycle, in which case pcm_valid stays 1 with new data.
REQ-026 SHALL treat a window completion while pcm_valid=1 and pcm_ready=0 as an overflow: the new sample is dropped, the old one is kept, overflow is set and ovf_count increments (if compiled).
REQ-027 SHALL treat completion coincident with acceptance as no overflow.
REQ-028 SHALL saturate ovf_count at 16'hFFFF.

Reset
REQ-029 SHALL, on reset low, clear asynchronously: state=IDLE, mic_clk=0, divider=0, synchronizer=0, accumulator=0, bit count=0, window count=0, pcm_data=0, pcm_valid=0, overflow=0, ovf_count=0.
REQ-030 SHALL synchronize reset release internally; capture starts no earlier than the second clk edge after deassertion.

Configuration
REQ-031 SHALL implement the ovf_count register and its increment only when macro PDM_CAPTURE_OVF_CNT_EN is defined.
REQ-032 SHALL, without PDM_CAPTURE_OVF_CNT_EN, keep port ovf_count and tie it to 0, with the overflow flag unchanged.

Structure
REQ-033 SHALL place the state enum type and default constants (CLK_DIV, DECIM, WARMUP_WIN) in shared package pdm_pkg.
REQ-034 SHALL put mic_clk generation and the rise-event pulse in sub-module pdm_clkgen.

Verification
REQ-035 SHALL verify: mic_data=1 constant, enable=1, pcm_ready=1 -> third and later samples pcm_data=64; first pcm_valid at 3*6400 clk cycles plus sync latency.
REQ-036 SHALL verify: mic_data alternating 1/0 per mic_clk rise -> every sample = 32.
REQ-037 SHALL verify: pcm_ready=0 for 2 windows -> first sample held stable, overflow=1, ovf_count=1; with the macro undefined, ovf_count=0.
REQ-038 SHALL verify: enable dropped mid-window -> mic_clk=0 within 1 clk, state IDLE, no pcm_valid; re-enable -> WARMUP repeats.
REQ-039 SHALL verify: reset asserted mid-RUN with pcm_valid=1 -> all outputs 0 immediately, without waiting for a clk edge.
REQ-040 SHALL verify: pcm_ready pulsed in the same cycle as the next completion -> pcm_valid stays 1 with new data, overflow stays 0.
